dataset_row_reader: RTL and testbench
=====================================

Name: dataset_row_reader

Overview:
- Downstream consumer of the serial-load stage.
- Once the dataset RAM holds rows 0..num_dp, each row 256 bits wide (16 slots of 16 bits), this block reads the rows back in address order.
- Each row is unpacked into a zero-masked feature vector plus a target value and streamed over a valid/ready handshake to the regression datapath.
- Optionally repeats the full pass for several epochs.

Parameters:
- ADDR_WIDTH, 12, RAM address width.
- MAX_FEATURES, 15, number of feature slots in the output vector.
- LENGTH, 16, bits per slot.
- DATA_WIDTH, LENGTH*(MAX_FEATURES+1) = 256, RAM row width.
- RD_LAT, 1, RAM read latency in cycles; fixed at 1 for this revision.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a read pass.
- abort  in  1  synchronous abort; returns to IDLE.
- load_done  in  1  done flag from the serial-load stage; start is ignored while it is low.
- num_dp  in  12  index of the last valid row (rows 0..num_dp inclusive).
- feat  in  4  number of features, 0..15.
- epochs  in  8  pass count; 0 is treated as 1.
- ram_addr  out  ADDR_WIDTH  RAM read address.
- ram_re  out  1  RAM read enable.
- ram_rdata  in  DATA_WIDTH  RAM read data, valid RD_LAT cycles after ram_re.
- x_vec  out  LENGTH*MAX_FEATURES  packed features; feature i at bits [16i+15:16i].
- y  out  LENGTH  target value.
- row_idx  out  ADDR_WIDTH  row number of the current output.
- last_row  out  1  current output is row num_dp.
- last_epoch  out  1  current output belongs to the final pass.
- out_valid  out  1  output holds a row.
- out_ready  in  1  consumer accepts the row.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  high in DONE until the next start or abort.

Behaviour:
- Reset (RST_N=0, asynchronous): state=IDLE. Every output is 0: ram_addr, ram_re, x_vec, y, row_idx, last_row, last_epoch, out_valid, busy, done. Epoch counter is 0.
- Row layout: slot s occupies bits [16s+15:16s]. y is slot 15. Feature i (i<feat) is slot 15-feat+i. Slots below 15-feat are ignored.
- Unpack: x_vec feature i = slot(15-feat+i) for i<feat; feature i = 0 for i>=feat. With feat=0, x_vec is all zero.
- feat and num_dp are sampled into internal registers on the accepted start; later changes have no effect on the pass in progress.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, DONE.
  - IDLE: start & load_done -> ISSUE, with addr=0, epoch=0, done cleared. start while load_done=0 is ignored.
  - ISSUE: ram_re=1 for exactly one cycle at ram_addr -> WAIT.
  - WAIT: capture ram_rdata at the end of the RD_LAT cycle, unpack into the output registers, set out_valid=1 -> PRESENT.
  - PRESENT: hold all outputs stable while out_valid & !out_ready. On out_valid & out_ready, out_valid drops and the next state is:
    - DONE, if addr==num_dp and epoch==epochs-1 (epochs 0 treated as 1).
    - ISSUE with addr+1, if addr!=num_dp.
    - ISSUE with addr=0 and epoch+1, otherwise (end of a non-final pass).
  - DONE: done=1. A new start & load_done -> ISSUE and clears done.
- Throughput: one row per 3 cycles when out_ready is held high.
- Latency: first out_valid appears 3 cycles after the start pulse (start cycle -> ISSUE -> WAIT -> out_valid rises).
- ram_re is asserted only in ISSUE. ram_addr holds its value outside ISSUE.
- start while busy is ignored.
- abort has priority over every transition: next cycle state=IDLE, out_valid=0, done=0.
- num_dp = 4095: row index comparison is done before increment, so the address never wraps.
- row_idx = the address used for the current output. last_row and last_epoch are registered together with the data.

Decomposition:
- Shared package holds: LENGTH, MAX_FEATURES, DATA_WIDTH, ADDR_WIDTH, the FSM state encoding, and a slot-offset constant function (slot index from feat and i). The serial-load stage uses the same package.
- One sub-module, row_unpack: combinational slot select and masking from (row, feat) to (x_vec, y), instantiated once.

Test Plan:
- Reset mid-PRESENT: drop RST_N -> all outputs 0 immediately, without waiting for a clock edge.
- feat=3, num_dp=2, epochs=1, row0 slots 12..15 = 0x0011, 0x0022, 0x0033, 0x0044, out_ready=1 -> x_vec[47:0] = {0x0033, 0x0022, 0x0011}, upper bits 0, y=0x0044. Three rows are emitted, last_row=1 on row 2, done follows.
- Backpressure: out_ready=0 for 5 cycles on row 1 -> outputs stable, no further ram_re; the handshake completes on the first cycle out_ready=1.
- epochs=2, num_dp=1 -> output row_idx sequence 0,1,0,1; last_epoch=1 only on the final two rows.
- start with load_done=0 -> stays IDLE, no ram_re. Second start while busy -> ignored, sequence unchanged.
- feat=15, slot0 = 0xFFFF; feat=0 -> x_vec all zero, y = slot 15. abort in WAIT -> IDLE next cycle, out_valid stays 0.

Source files
------------

// File: rtl/dataset_row_reader_pkg.sv
// Shared definitions for the dataset load/read path.
// Holds the row geometry (slot width, feature count, RAM row and address
// widths), the reader FSM state encoding and the slot-offset helper that
// maps (feat, feature index) to the RAM slot holding that feature.
package dataset_row_reader_pkg;

  localparam int ADDR_WIDTH   = 12;
  localparam int MAX_FEATURES = 15;
  localparam int LENGTH       = 16;
  localparam int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1);
  localparam int X_WIDTH      = LENGTH * MAX_FEATURES;
  localparam int RD_LAT       = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Features are packed against the target slot: feature i of a row with
  // feat features lives in slot 15-feat+i. Only meaningful for i < feat,
  // where the 4-bit result cannot wrap.
  function automatic logic [3:0] slot_idx(input logic [3:0] feat, input logic [3:0] i);
    logic [3:0] s;
    s = 4'd15 - feat + i;
    return s;
  endfunction

endpackage

// File: rtl/dataset_row_reader_row_unpack.sv
// row_unpack: combinational unpack of one 256-bit dataset row.
// Ports:
//   row   - raw RAM row, slot s at bits [16s+15:16s]
//   feat  - number of valid features (0..15)
//   x_vec - feature i at bits [16i+15:16i], zero for i >= feat
//   y     - target value (slot 15)
module row_unpack
  import dataset_row_reader_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] row,
  input  logic [3:0]            feat,
  output logic [X_WIDTH-1:0]    x_vec,
  output logic [LENGTH-1:0]     y
);

  always_comb begin
    x_vec = '0;
    for (int i = 0; i < MAX_FEATURES; i++) begin
      if (i < int'(feat)) begin
        x_vec[i*LENGTH +: LENGTH] = row[slot_idx(feat, 4'(i))*LENGTH +: LENGTH];
      end
    end
  end

  assign y = row[DATA_WIDTH-1 -: LENGTH];

endmodule

// File: rtl/dataset_row_reader.sv
// dataset_row_reader: streams dataset rows 0..num_dp out of the dataset RAM,
// unpacked into (x_vec, y), over a valid/ready handshake, for one or more
// epochs.
// Ports:
//   CLK, RST_N            - clock, async active-low reset
//   start, abort          - pass start pulse (needs load_done), sync abort
//   load_done             - serial-load stage finished
//   num_dp, feat, epochs  - last row index, feature count, pass count (0 = 1)
//   ram_addr, ram_re      - RAM read port, ram_rdata valid one cycle after ram_re
//   x_vec, y, row_idx     - current output row
//   last_row, last_epoch  - output row is row num_dp / in the final pass
//   out_valid, out_ready  - output handshake
//   busy, done            - pass running / pass finished
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start & load_done
// S_ISSUE   | ram_re high for one cycle at ram_addr
// S_WAIT    | RAM read in flight, row captured at cycle end
// S_PRESENT | out_valid high, waiting for out_ready
// S_DONE    | all passes emitted, done high
module dataset_row_reader
  import dataset_row_reader_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  load_done,
  input  logic [ADDR_WIDTH-1:0] num_dp,
  input  logic [3:0]            feat,
  input  logic [7:0]            epochs,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [X_WIDTH-1:0]    x_vec,
  output logic [LENGTH-1:0]     y,
  output logic [ADDR_WIDTH-1:0] row_idx,
  output logic                  last_row,
  output logic                  last_epoch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  state_t                state;
  logic [7:0]            epoch;
  logic [7:0]            epoch_final;
  logic [3:0]            feat_r;
  logic [ADDR_WIDTH-1:0] num_dp_r;
  logic [X_WIDTH-1:0]    x_unp;
  logic [LENGTH-1:0]     y_unp;

  // A pass count of zero runs a single pass.
  assign epoch_final = (epochs == 8'd0) ? 8'd0 : epochs - 8'd1;

  row_unpack u_unpack (
    .row   (ram_rdata),
    .feat  (feat_r),
    .x_vec (x_unp),
    .y     (y_unp)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      epoch      <= '0;
      feat_r     <= '0;
      num_dp_r   <= '0;
      ram_addr   <= '0;
      ram_re     <= 1'b0;
      x_vec      <= '0;
      y          <= '0;
      row_idx    <= '0;
      last_row   <= 1'b0;
      last_epoch <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state     <= S_IDLE;
      ram_re    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start && load_done) begin
            state    <= S_ISSUE;
            ram_addr <= '0;
            epoch    <= '0;
            feat_r   <= feat;
            num_dp_r <= num_dp;
            ram_re   <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_ISSUE: begin
          ram_re <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          x_vec      <= x_unp;
          y          <= y_unp;
          row_idx    <= ram_addr;
          last_row   <= (ram_addr == num_dp_r);
          last_epoch <= (epoch == epoch_final);
          out_valid  <= 1'b1;
          state      <= S_PRESENT;
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Compare before incrementing so num_dp = 4095 never wraps.
            if (ram_addr != num_dp_r) begin
              ram_addr <= ram_addr + 1'b1;
              ram_re   <= 1'b1;
              state    <= S_ISSUE;
            end else if (epoch != epoch_final) begin
              ram_addr <= '0;
              epoch    <= epoch + 8'd1;
              ram_re   <= 1'b1;
              state    <= S_ISSUE;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          ram_re <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dataset_row_reader.sv
module tb_dataset_row_reader;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         start, abort, load_done, out_ready;
  logic [11:0]  num_dp;
  logic [3:0]   feat;
  logic [7:0]   epochs;
  logic [11:0]  ram_addr;
  logic         ram_re;
  logic [255:0] ram_rdata = '0;
  logic [239:0] x_vec;
  logic [15:0]  y;
  logic [11:0]  row_idx;
  logic         last_row, last_epoch, out_valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [255:0] mem [0:3];

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (ram_re) ram_rdata <= mem[ram_addr[1:0]];

  dataset_row_reader dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .load_done(load_done),
    .num_dp(num_dp), .feat(feat), .epochs(epochs),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .x_vec(x_vec), .y(y), .row_idx(row_idx), .last_row(last_row),
    .last_epoch(last_epoch), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (out_valid !== 1'b1 && n < max) begin
      @(negedge CLK);
      n++;
    end
    chk("valid_within_budget", out_valid, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  int          rre_cnt;
  logic [11:0] exp_idx [4] = '{12'd0, 12'd1, 12'd0, 12'd1};
  logic        exp_lr  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic        exp_le  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] exp_y   [4] = '{16'h0044, 16'h1044, 16'h0044, 16'h1044};

  initial begin
    // Row r, slot s: slots 12..15 = r*0x1000 + (s-11)*0x11, others r*0x1000 + 0x0A00 + s.
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < 16; s++) begin
        if (s >= 12) mem[r][s*16 +: 16] = 16'(r*16'h1000 + (s-11)*16'h0011);
        else         mem[r][s*16 +: 16] = 16'(r*16'h1000 + 16'h0A00 + s);
      end
    end
    mem[0][15:0] = 16'hFFFF;

    RST_N = 1'b0; start = 0; abort = 0; load_done = 0; out_ready = 0;
    num_dp = 0; feat = 0; epochs = 0;
    #3;
    chk("rst_ctrl", {ram_re, out_valid, busy, done, last_row, last_epoch}, 6'b0);
    chk("rst_data", {y, row_idx, ram_addr}, 40'h0);
    chk("rst_xvec", x_vec, 240'h0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    // feat=3, num_dp=2, one pass, backpressure on row 1
    feat = 3; num_dp = 2; epochs = 1; out_ready = 1; load_done = 1;
    pulse_start();
    chk("a_issue", {ram_re, ram_addr, busy, done}, {1'b1, 12'd0, 1'b1, 1'b0});
    @(negedge CLK);
    chk("a_wait", {out_valid, ram_re}, 2'b00);
    @(negedge CLK);
    chk("a_lat_valid", out_valid, 1'b1);
    chk("a_r0_x", x_vec[47:0], 48'h0033_0022_0011);
    chk("a_r0_xhi", x_vec[239:48], 192'h0);
    chk("a_r0_meta", {y, row_idx, last_row, last_epoch}, {16'h0044, 12'd0, 1'b0, 1'b1});
    @(negedge CLK);
    out_ready = 0;
    chk("a_r0_accepted", out_valid, 1'b0);
    wait_valid(10);
    chk("a_r1_x", x_vec[47:0], 48'h1033_1022_1011);
    chk("a_r1_y", y, 16'h1044);
    rre_cnt = 0;
    start = 1'b1;  // ignored while busy
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      start = 1'b0;
      if (ram_re) rre_cnt++;
      chk("a_bp_hold", {out_valid, y, row_idx, x_vec[47:0]},
          {1'b1, 16'h1044, 12'd1, 48'h1033_1022_1011});
    end
    chk("a_bp_no_re", rre_cnt, 0);
    out_ready = 1;
    @(negedge CLK);
    chk("a_bp_release", {out_valid, ram_re, ram_addr}, {1'b0, 1'b1, 12'd2});
    wait_valid(10);
    chk("a_r2", {y, row_idx, last_row}, {16'h2044, 12'd2, 1'b1});
    @(negedge CLK);
    chk("a_done", {done, busy, out_valid}, 3'b100);

    // feat=0, num_dp=1, two passes
    feat = 0; num_dp = 1; epochs = 2;
    pulse_start();
    chk("b_done_clr", {done, busy}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      wait_valid(10);
      chk("b_xvec", x_vec, 240'h0);
      chk("b_row", {row_idx, last_row, last_epoch, y}, {exp_idx[k], exp_lr[k], exp_le[k], exp_y[k]});
      @(negedge CLK);
    end
    chk("b_done", {done, busy}, 2'b10);

    // feat=15, single row, epochs=0 -> one pass; feat changed after start
    feat = 15; num_dp = 0; epochs = 0;
    pulse_start();
    feat = 0;
    wait_valid(10);
    chk("c_f0", x_vec[15:0], 16'hFFFF);
    chk("c_f1", x_vec[31:16], 16'h0A01);
    chk("c_f14", x_vec[239:224], 16'h0033);
    chk("c_meta", {y, last_row, last_epoch}, {16'h0044, 1'b1, 1'b1});
    @(negedge CLK);
    chk("c_done", done, 1'b1);

    // start without load_done
    load_done = 0;
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      chk("d_no_load", {busy, ram_re, done}, 3'b001);
      @(negedge CLK);
    end

    // abort during WAIT
    load_done = 1; feat = 3; num_dp = 2; epochs = 1;
    pulse_start();
    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("e_abort", {out_valid, busy, done, ram_re}, 4'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      chk("e_idle", {out_valid, ram_re, busy}, 3'b0);
    end

    // async reset while presenting
    out_ready = 0;
    pulse_start();
    wait_valid(10);
    #2;
    RST_N = 1'b0;
    #1;
    chk("f_rst_ctrl", {ram_re, out_valid, busy, done, last_row, last_epoch}, 6'b0);
    chk("f_rst_data", {y, row_idx, ram_addr}, 40'h0);
    chk("f_rst_xvec", x_vec, 240'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
